// File: rtl/bus_xfer_ctrl_if.sv
// rtl/bus_xfer_ctrl_if.sv - command handshake and bus enable/load bundle for bus_xfer_ctrl
interface bus_xfer_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_src;
  logic [2:0] cmd_dst;
  logic       eni;
  logic       ena;
  logic       enb;
  logic       enc;
  logic       lda;
  logic       ldb;
  logic       ldc;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] xfer_cnt;

  modport master (
    output cmd_valid, cmd_src, cmd_dst,
    input  cmd_ready, eni, ena, enb, enc, lda, ldb, ldc, busy, done, err, xfer_cnt
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst,
    output cmd_ready, eni, ena, enb, enc, lda, ldb, ldc, busy, done, err, xfer_cnt
  );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - shared-bus transfer sequencer with 2-entry command FIFO
// Replays queued {src, dst} commands as drive-settle-load sequences with one driver per cycle.
module bus_xfer_ctrl #(
  parameter int SETTLE = 1
) (
  input logic            clk,
  input logic            rst,
  bus_xfer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, LOAD} state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [4:0] fifo_q [2];
  logic [4:0] fifo_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic [3:0] settle_q, settle_d;
  logic [1:0] src_q, src_d;
  logic [2:0] mask_q, mask_d;
  logic [3:0] en_q, en_d;
  logic [2:0] ld_q, ld_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] xfer_cnt_q, xfer_cnt_d;

  logic       full;
  logic       push;
  logic       pop;
  logic [4:0] head;
  logic [1:0] head_src;
  logic [2:0] head_mask;

  // Register bit a source would otherwise load from itself; the input buffer has none.
  function automatic logic [2:0] self_bit(input logic [1:0] src);
    case (src)
      2'd1:    self_bit = 3'b001;
      2'd2:    self_bit = 3'b010;
      2'd3:    self_bit = 3'b100;
      default: self_bit = 3'b000;
    endcase
  endfunction

  always_comb begin
    full      = (count_q == 2'd2);
    push      = bus.cmd_valid && !full;
    pop       = (state_q == IDLE) && (count_q != 2'd0);
    head      = fifo_q[rd_ptr_q];
    head_src  = head[4:3];
    head_mask = head[2:0] & ~self_bit(head_src);

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {bus.cmd_src, bus.cmd_dst};
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    src_d    = src_q;
    mask_d   = mask_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          src_d  = head_src;
          mask_d = head_mask;
          if (head_mask != 3'b000) begin
            state_d  = DRIVE;
            settle_d = SETTLE_M1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (settle_q == 4'd0) begin
          state_d = LOAD;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so every strobe comes straight off a flop.
    en_d       = (state_d != IDLE) ? (4'b0001 << src_d) : 4'b0000;
    ld_d       = (state_d == LOAD) ? mask_d : 3'b000;
    done_d     = (state_q == LOAD);
    xfer_cnt_d = xfer_cnt_q + {7'd0, done_d};
    busy_d     = (state_d != IDLE) || (count_d != 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fifo_q     <= '{default: 5'd0};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      settle_q   <= 4'd0;
      src_q      <= 2'd0;
      mask_q     <= 3'd0;
      en_q       <= 4'd0;
      ld_q       <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      xfer_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      settle_q   <= settle_d;
      src_q      <= src_d;
      mask_q     <= mask_d;
      en_q       <= en_d;
      ld_q       <= ld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign bus.cmd_ready = !full;
  assign bus.eni       = en_q[0];
  assign bus.ena       = en_q[1];
  assign bus.enb       = en_q[2];
  assign bus.enc       = en_q[3];
  assign bus.lda       = ld_q[0];
  assign bus.ldb       = ld_q[1];
  assign bus.ldc       = ld_q[2];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb/tb_bus_xfer_ctrl.sv - directed self-checking bench for bus_xfer_ctrl
module tb_bus_xfer_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_xfer_ctrl_if b1();
  bus_xfer_ctrl_if b3();

  bus_xfer_ctrl #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  bus_xfer_ctrl #(.SETTLE(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Register file on the shared bus, fed by dut1.
  logic [7:0] in_data, rega, regb, regc, zbus;
  always_comb begin
    zbus = 8'h00;
    if (b1.eni) zbus = in_data;
    else if (b1.ena) zbus = rega;
    else if (b1.enb) zbus = regb;
    else if (b1.enc) zbus = regc;
  end
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rega <= 8'h00; regb <= 8'h00; regc <= 8'h00;
    end else begin
      if (b1.lda) rega <= zbus;
      if (b1.ldb) regb <= zbus;
      if (b1.ldc) regc <= zbus;
    end
  end

  // Monitor on dut1: enable run lengths, their source, idle gaps and load placement.
  logic [3:0] en_vec, prev_en;
  logic [2:0] ld_vec;
  assign en_vec = {b1.enc, b1.enb, b1.ena, b1.eni};
  assign ld_vec = {b1.ldc, b1.ldb, b1.lda};
  int run_len = 0, zero_len = 0, ld_cyc = 0, err_cyc = 0, en_cyc = 0, overlap = 0, ld_bad = 0;
  bit seen_xfer = 0, prev_ld = 0;
  int runs[$];
  int run_src[$];
  int gaps[$];
  logic [2:0] ld_log[$];

  function automatic int src_of(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 9;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_en = 4'd0; prev_ld = 0; seen_xfer = 0; run_len = 0; zero_len = 0;
    end else begin
      if ($countones(en_vec) > 1) overlap++;
      if (prev_en != 4'd0 && en_vec != prev_en) begin
        runs.push_back(run_len);
        run_src.push_back(src_of(prev_en));
        seen_xfer = 1;
        zero_len = 0;
      end
      if (en_vec != 4'd0 && en_vec != prev_en) begin
        if (seen_xfer) gaps.push_back(zero_len);
        run_len = 0;
      end
      if (en_vec != 4'd0) begin
        run_len++; en_cyc++;
      end else begin
        zero_len++;
      end
      if (prev_ld && en_vec == prev_en) ld_bad++;
      if (ld_vec != 3'd0) begin
        ld_cyc++;
        ld_log.push_back(ld_vec);
        if (en_vec == 4'd0) ld_bad++;
      end
      if (b1.err) err_cyc++;
      prev_en = en_vec;
      prev_ld = (ld_vec != 3'd0);
    end
  end

  logic [1:0] bs [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic [2:0] bd [4] = '{3'b010, 3'b100, 3'b001, 3'b010};

  task automatic set_cmd(input bit sel, input logic v, input logic [1:0] s, input logic [2:0] d);
    if (sel) begin
      b3.cmd_valid = v; b3.cmd_src = s; b3.cmd_dst = d;
    end else begin
      b1.cmd_valid = v; b1.cmd_src = s; b1.cmd_dst = d;
    end
  endtask

  function automatic logic ready_of(input bit sel);
    return sel ? b3.cmd_ready : b1.cmd_ready;
  endfunction

  task automatic push(input bit sel, input logic [1:0] s, input logic [2:0] d);
    int t = 0;
    set_cmd(sel, 1'b1, s, d);
    while (!ready_of(sel) && t < 50) begin
      @(posedge clk); #1; t++;
    end
    @(posedge clk); #1;
    set_cmd(sel, 1'b0, s, d);
    if (t >= 50) check("push_timeout", t, 0);
  endtask

  task automatic wait_idle(input bit sel, input int budget, output int cyc);
    cyc = 0;
    while ((sel ? b3.busy : b1.busy) && cyc < budget) begin
      @(posedge clk); #1; cyc++;
    end
    if (cyc >= budget) check("idle_timeout", cyc, 0);
  endtask

  task automatic burst1(input int n, output int low_at);
    int k = 0, t = 0;
    logic r;
    low_at = -1;
    b1.cmd_valid = 1'b1;
    while (k < n && t < 200) begin
      b1.cmd_src = bs[k]; b1.cmd_dst = bd[k];
      r = b1.cmd_ready;
      if (!r && low_at < 0) low_at = k;
      @(posedge clk); #1; t++;
      if (r) k++;
    end
    b1.cmd_valid = 1'b0;
    if (k < n) check("burst1_timeout", k, n);
  endtask

  task automatic burst3(input int n);
    int k = 0, t = 0;
    logic r;
    set_cmd(1'b1, 1'b1, 2'd0, 3'b100);
    while (k < n && t < n * 8 + 20) begin
      r = b3.cmd_ready;
      @(posedge clk); #1; t++;
      if (r) k++;
    end
    b3.cmd_valid = 1'b0;
    if (k < n) check("burst3_timeout", k, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, rb, lb, eb, gb, low, en_n, ld_n, ld_pos, done_pos;
    set_cmd(1'b0, 1'b0, 2'd0, 3'd0);
    set_cmd(1'b1, 1'b0, 2'd0, 3'd0);
    in_data = 8'hAA;
    repeat (2) @(posedge clk); #1;

    check("rst_ready", b1.cmd_ready, 1);
    check("rst_busy", b1.busy, 0);
    check("rst_cnt", b1.xfer_cnt, 0);
    check("rst_en", {b1.eni, b1.ena, b1.enb, b1.enc}, 0);
    check("rst_ld_done_err", {b1.lda, b1.ldb, b1.ldc, b1.done, b1.err}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic: input buffer -> A
    rb = runs.size(); lb = ld_cyc;
    push(1'b0, 2'd0, 3'b001);
    wait_idle(1'b0, 20, cyc);
    check("basic_latency", cyc, 3);
    check("basic_done", b1.done, 1);
    check("basic_cnt", b1.xfer_cnt, 1);
    check("basic_rega", rega, 8'hAA);
    repeat (2) @(posedge clk); #1;
    check("basic_runs", runs.size() - rb, 1);
    check("basic_en_len", runs[rb], 2);
    check("basic_src", run_src[rb], 0);
    check("basic_ld_cyc", ld_cyc - lb, 1);
    check("basic_ld_mask", ld_log[lb], 3'b001);
    check("basic_done_gone", b1.done, 0);

    // multicast: A -> B and C
    rb = runs.size(); lb = ld_cyc;
    push(1'b0, 2'd1, 3'b110);
    wait_idle(1'b0, 20, cyc);
    check("mc_cnt", b1.xfer_cnt, 2);
    repeat (2) @(posedge clk); #1;
    check("mc_en_len", runs[rb], 2);
    check("mc_src", run_src[rb], 1);
    check("mc_ld_cyc", ld_cyc - lb, 1);
    check("mc_ld_mask", ld_log[lb], 3'b110);
    check("mc_regb", regb, 8'hAA);
    check("mc_regc", regc, 8'hAA);

    // self-load only: dropped
    rb = runs.size(); lb = ld_cyc; eb = err_cyc;
    push(1'b0, 2'd2, 3'b010);
    wait_idle(1'b0, 20, cyc);
    repeat (2) @(posedge clk); #1;
    check("drop_err", err_cyc - eb, 1);
    check("drop_runs", runs.size() - rb, 0);
    check("drop_ld", ld_cyc - lb, 0);
    check("drop_cnt", b1.xfer_cnt, 2);

    // self bit stripped from a mixed mask
    rb = runs.size(); lb = ld_cyc;
    push(1'b0, 2'd2, 3'b011);
    wait_idle(1'b0, 20, cyc);
    repeat (2) @(posedge clk); #1;
    check("strip_ld_mask", ld_log[lb], 3'b001);
    check("strip_src", run_src[rb], 2);
    check("strip_cnt", b1.xfer_cnt, 3);

    // backpressure: 4 commands with valid held high
    rb = runs.size(); gb = gaps.size();
    burst1(4, low);
    check("bp_ready_low_at", low, 3);
    wait_idle(1'b0, 100, cyc);
    repeat (3) @(posedge clk); #1;
    check("bp_runs", runs.size() - rb, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_src_%0d", i), run_src[rb + i], i);
      check($sformatf("bp_len_%0d", i), runs[rb + i], 2);
    end
    check("bp_gaps", gaps.size() - gb, 4);
    for (int i = 1; i < 4; i++) check($sformatf("bp_gap_%0d", i), gaps[gb + i], 1);
    check("bp_cnt", b1.xfer_cnt, 7);
    check("overlap", overlap, 0);
    check("ld_placement", ld_bad, 0);

    // reset during LOAD with two commands queued
    burst1(3, low);
    check("pre_rst_en", {b1.eni, b1.ena, b1.enb, b1.enc}, 4'b1000);
    check("pre_rst_ld", {b1.ldc, b1.ldb, b1.lda}, 3'b010);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_en", {b1.eni, b1.ena, b1.enb, b1.enc}, 0);
    check("rst_mid_ld", {b1.lda, b1.ldb, b1.ldc}, 0);
    check("rst_mid_flags", {b1.busy, b1.done, b1.err}, 0);
    check("rst_mid_ready", b1.cmd_ready, 1);
    check("rst_mid_cnt", b1.xfer_cnt, 0);
    eb = en_cyc; lb = ld_cyc; rb = runs.size();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk); #1;
    check("post_rst_busy", b1.busy, 0);
    check("post_rst_ready", b1.cmd_ready, 1);
    check("post_rst_cnt", b1.xfer_cnt, 0);
    check("post_rst_en", en_cyc - eb, 0);
    check("post_rst_ld", ld_cyc - lb, 0);
    check("post_rst_regb", regb, 8'h00);

    // SETTLE=3 instance: enable 4 cycles, load on the 4th
    push(1'b1, 2'd0, 3'b100);
    en_n = 0; ld_n = 0; ld_pos = 0; done_pos = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (b3.eni) en_n++;
      if (b3.ldc) begin
        ld_n++; ld_pos = en_n;
      end
      if (b3.done && done_pos == 0) done_pos = i;
    end
    check("s3_en_len", en_n, 4);
    check("s3_ld_len", ld_n, 1);
    check("s3_ld_pos", ld_pos, 4);
    check("s3_done_pos", done_pos, 5);
    check("s3_cnt", b3.xfer_cnt, 1);

    // counter wrap on the SETTLE=3 instance
    burst3(254);
    wait_idle(1'b1, 50, cyc);
    check("s3_cnt_255", b3.xfer_cnt, 255);
    push(1'b1, 2'd0, 3'b100);
    wait_idle(1'b1, 50, cyc);
    check("s3_wrap_done", b3.done, 1);
    check("s3_wrap_cnt", b3.xfer_cnt, 0);
    check("s3_wrap_err", b3.err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
